// File: rtl/adder_bist_if.sv
// Operand/result and control/status bundle between the adder BIST driver and its surroundings.
// master = BIST driver side; slave = adder plus run controller side.
interface adder_bist_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [7:0]       dut_sum;
   logic             busy;
   logic             done;
   logic             pass;
   logic [7:0]       err_count;
   logic [WIDTH-1:0] fail_a;
   logic [WIDTH-1:0] fail_b;
   logic [7:0]       fail_sum;

   modport master (
      input  start, abort, dut_sum,
      output op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_sum
   );

   modport slave (
      output start, abort, dut_sum,
      input  op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_sum
   );
endinterface

// File: rtl/adder_bist_driver.sv
// Adder BIST: drives operand pairs (LFSR, or full sweep with ADDER_BIST_EXHAUSTIVE_EN), checks dut_sum against a+b.
// Timing: vector k loads at E0+k*(LATENCY+1), sum sampled LATENCY edges later; done at E0+N*(LATENCY+1).
// Control: start only accepted from idle/done; abort returns to idle keeping results; no other backpressure.
module adder_bist_driver #(
   parameter int         WIDTH       = 4,
   parameter int         NUM_VECTORS = 16,
   parameter int         LATENCY     = 1,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_bist_if.master bus
);
   localparam logic [7:0] SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam int         LW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   op_a_q, op_b_q, fail_a_q, fail_b_q;
   logic [7:0]         err_q, fail_sum_q;
   logic               pass_q;
   logic [LW-1:0]      lat_cnt;
   logic               busy_c, done_c;
   logic               first_load, load_en, sample_en, finish, last_vec;
   logic [2*WIDTH-1:0] vec_next;
   logic [WIDTH:0]     sum_exp;
   logic               mismatch;

`ifdef ADDER_BIST_EXHAUSTIVE_EN
   // The operand registers double as the sweep counter, op_a in the low half.
   assign last_vec = &{op_b_q, op_a_q};
   assign vec_next = first_load ? '0 : ({op_b_q, op_a_q} + (2*WIDTH)'(1));
`else
   logic [7:0]  lfsr, lfsr_src;
   logic [15:0] vec_cnt;

   assign last_vec = (vec_cnt == 16'(NUM_VECTORS - 1));
   assign lfsr_src = first_load ? SEED : lfsr;
   assign vec_next = lfsr_src[2*WIDTH-1:0];

   // Fibonacci taps for x^8+x^6+x^5+x^4+1; lfsr always holds the state for the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr    <= SEED;
         vec_cnt <= '0;
      end else if (load_en) begin
         lfsr    <= {lfsr_src[6:0], lfsr_src[7] ^ lfsr_src[5] ^ lfsr_src[4] ^ lfsr_src[3]};
         vec_cnt <= first_load ? 16'd0 : (vec_cnt + 16'd1);
      end
   end
`endif

   assign sum_exp  = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign mismatch = (bus.dut_sum != 8'(sum_exp));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (bus.start && !bus.abort) state_nxt = S_DRIVE;
            S_DRIVE:        state_nxt = (LATENCY == 1) ? S_CHECK : S_WAIT;
            S_WAIT:         if (lat_cnt == LAT_LAST) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = last_vec ? S_DONE : S_DRIVE;
            default:        state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_c     = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
      done_c     = (state == S_DONE);
      load_en    = (state_nxt == S_DRIVE);
      first_load = load_en && ((state == S_IDLE) || (state == S_DONE));
      sample_en  = (state_nxt == S_CHECK);
      finish     = (state == S_CHECK) && (state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q     <= '0;
         op_b_q     <= '0;
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         fail_sum_q <= '0;
         err_q      <= '0;
         pass_q     <= 1'b0;
         lat_cnt    <= '0;
      end else begin
         if (state == S_DRIVE)     lat_cnt <= '0;
         else if (state == S_WAIT) lat_cnt <= lat_cnt + LW'(1);

         if (first_load) begin
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sum_q <= '0;
            pass_q     <= 1'b0;
         end
         if (load_en) {op_b_q, op_a_q} <= vec_next;

         // Only the first mismatch of a run is captured; the count saturates.
         if (sample_en && mismatch) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (err_q == 8'h00) begin
               fail_a_q   <= op_a_q;
               fail_b_q   <= op_b_q;
               fail_sum_q <= bus.dut_sum;
            end
         end
         if (finish) pass_q <= (err_q == 8'h00);
      end
   end

   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_a    = fail_a_q;
   assign bus.fail_b    = fail_b_q;
   assign bus.fail_sum  = fail_sum_q;
endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: behavioural adder with injectable faults plus a vector-list reference model.
module tb_adder_bist_driver;
   localparam int L = 1;
`ifdef ADDER_BIST_EXHAUSTIVE_EN
   localparam int N = 256;
`else
   localparam int N = 16;
`endif

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   mode;
   logic [7:0] corrupt [0:255];

   logic [3:0] va [0:N-1];
   logic [3:0] vb [0:N-1];
   logic [3:0] a0_exp, b0_exp;
   int         e_err;
   logic [3:0] e_fa, e_fb;
   logic [7:0] e_fs;
   logic       e_pass;

   adder_bist_if #(.WIDTH(4)) bus ();
   adder_bist_if #(.WIDTH(4)) bus0 ();

   adder_bist_driver #(.WIDTH(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   adder_bist_driver #(.WIDTH(4), .LFSR_SEED(8'h00)) u_dut_seed0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder under test: golden, sum bit 0 stuck low, or XOR-corrupted per operand pair.
   function automatic logic [7:0] tb_adder(input int m, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] s;
      s = {4'b0, a} + {4'b0, b};
      if (m == 1)      s[0] = 1'b0;
      else if (m == 2) s = s ^ corrupt[{b, a}];
      return s;
   endfunction

   always_comb bus.dut_sum  = tb_adder(mode, bus.op_a, bus.op_b);
   always_comb bus0.dut_sum = tb_adder(0, bus0.op_a, bus0.op_b);
   assign bus0.start = bus.start;
   assign bus0.abort = bus.abort;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic gen(input logic [7:0] seed);
      logic [7:0] s;
      s = (seed == 8'h00) ? 8'h01 : seed;
      for (int k = 0; k < N; k++) begin
`ifdef ADDER_BIST_EXHAUSTIVE_EN
         va[k] = 4'(k);
         vb[k] = 4'(k >> 4);
`else
         va[k] = s[3:0];
         vb[k] = s[7:4];
         s = {s[6:0], ^(s & 8'hB8)};
`endif
      end
   endtask

   task automatic compute(input int nchk);
      logic [7:0] obs;
      e_err = 0; e_fa = 4'h0; e_fb = 4'h0; e_fs = 8'h00;
      for (int k = 0; k < nchk; k++) begin
         obs = tb_adder(mode, va[k], vb[k]);
         if (int'(obs) != int'(va[k]) + int'(vb[k])) begin
            if (e_err == 0) begin
               e_fa = va[k]; e_fb = vb[k]; e_fs = obs;
            end
            if (e_err < 255) e_err++;
         end
      end
      e_pass = (e_err == 0);
   endtask

   // One run: optional spurious start at edge E0+spur, optional abort taking effect at edge E0+abort_at+1.
   task automatic run(input int mode_i, input int spur, input int abort_at, input bit chk0);
      int total, limit, nchk;
      total = N * (L + 1);
      limit = (abort_at >= 0) ? abort_at + 1 : total;
      nchk  = 0;
      for (int k = 0; k < N; k++) if (k * (L + 1) + L <= limit - 1) nchk++;
      mode = mode_i;
      compute(nchk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("e0_busy", 32'(bus.busy), 32'd1);
      chk("e0_done", 32'(bus.done), 32'd0);
      chk("e0_err_cleared", 32'(bus.err_count), 32'd0);
      chk("e0_op_a", 32'(bus.op_a), 32'(va[0]));
      chk("e0_op_b", 32'(bus.op_b), 32'(vb[0]));
      if (chk0) begin
         chk("seed0_op_a", 32'(bus0.op_a), 32'(a0_exp));
         chk("seed0_op_b", 32'(bus0.op_b), 32'(b0_exp));
      end
      for (int e = 1; e <= limit; e++) begin
         if (e == spur) bus.start = 1'b1;
         if (abort_at >= 0 && e == limit) bus.abort = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if (e % (L + 1) == 0 && e < total && !(abort_at >= 0 && e == limit)) begin
            chk("vec_op_a", 32'(bus.op_a), 32'(va[e / (L + 1)]));
            chk("vec_op_b", 32'(bus.op_b), 32'(vb[e / (L + 1)]));
         end
         if (e == total - 1) chk("done_early", 32'(bus.done), 32'd0);
      end
      chk("end_busy", 32'(bus.busy), 32'd0);
      chk("end_done", 32'(bus.done), (abort_at < 0) ? 32'd1 : 32'd0);
      chk("err_count", 32'(bus.err_count), 32'(e_err));
      chk("fail_a", 32'(bus.fail_a), 32'(e_fa));
      chk("fail_b", 32'(bus.fail_b), 32'(e_fb));
      chk("fail_sum", 32'(bus.fail_sum), 32'(e_fs));
      if (abort_at < 0) begin
         chk("pass", 32'(bus.pass), 32'(e_pass));
         chk("hold_op_a", 32'(bus.op_a), 32'(va[N-1]));
         chk("hold_op_b", 32'(bus.op_b), 32'(vb[N-1]));
      end
      if (chk0) begin
         chk("seed0_done", 32'(bus0.done), 32'd1);
         chk("seed0_pass", 32'(bus0.pass), 32'd1);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mode   = 0;
      for (int i = 0; i < 256; i++) corrupt[i] = 8'h00;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n     = 1'b0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_pass", 32'(bus.pass), 32'd0);
      chk("rst_err", 32'(bus.err_count), 32'd0);
      chk("rst_op_a", 32'(bus.op_a), 32'd0);
      chk("rst_op_b", 32'(bus.op_b), 32'd0);
      chk("rst_fail_sum", 32'(bus.fail_sum), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // start together with abort from idle must be ignored
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_busy", 32'(bus.busy), 32'd0);

      gen(8'h00);
      a0_exp = va[0];
      b0_exp = vb[0];
      gen(8'hA5);

      run(0, 5, -1, 1'b1);
      run(1, -1, -1, 1'b0);

      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_done_cleared", 32'(bus.done), 32'd0);
      chk("abort_err_kept", 32'(bus.err_count), 32'(e_err));

      for (int i = 0; i < 256; i++)
         corrupt[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run(2, -1, -1, 1'b0);
      run(1, -1, 10, 1'b0);

      // asynchronous reset in the middle of a failing run
      mode = 1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_err", 32'(bus.err_count), 32'd0);
      chk("mid_rst_op_a", 32'(bus.op_a), 32'd0);
      chk("mid_rst_op_b", 32'(bus.op_b), 32'd0);
      chk("mid_rst_fail_a", 32'(bus.fail_a), 32'd0);
      chk("mid_rst_fail_b", 32'(bus.fail_b), 32'd0);
      chk("mid_rst_fail_sum", 32'(bus.fail_sum), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, -1, -1, 1'b0);
      run(2, -1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
